// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back source select plus 32-entry GPR file with two
//            combinational read ports and same-cycle write-through bypass.
//            Optional trace outputs are enabled by defining WB_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWrite_in,
    input  logic [1:0]    MemtoReg_in,
    input  logic [DW-1:0] rd_in,
    input  logic [DW-1:0] alu_result_in,
    input  logic [31:0]   wa_in,
    input  logic [DW-1:0] pc4_in,
    input  logic [31:0]   instr_in,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data
`ifdef WB_TRACE_EN
    ,
    output logic [31:0]   retire_cnt,
    output logic [AW-1:0] last_wb_addr
`endif
);

    localparam logic [1:0] c_SEL_MEM  = 2'b01;
    localparam logic [1:0] c_SEL_LINK = 2'b10;

    logic [DW-1:0] r_gpr [NREG];

    // Upper index bits are ignored by design; instr_in only feeds the trace build.
    logic w_unused;
    assign w_unused = ^{wa_in[31:AW], instr_in};

    always_comb begin
        wb_data = alu_result_in;
        case (MemtoReg_in)
            c_SEL_MEM:  wb_data = rd_in;
            c_SEL_LINK: wb_data = pc4_in;
            default:    wb_data = alu_result_in;
        endcase
    end

    assign wb_addr = wa_in[AW-1:0];
    assign wb_en   = RegWrite_in & (wb_addr != '0) & ~rst;

    // Reset wins over a colliding write because wb_en already excludes rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (wb_en) begin
            r_gpr[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd1 = r_gpr[ra1];
        if (rst || (ra1 == '0)) begin
            rd1 = '0;
        end else if (wb_en && (ra1 == wb_addr)) begin
            rd1 = wb_data;
        end
    end

    always_comb begin
        rd2 = r_gpr[ra2];
        if (rst || (ra2 == '0)) begin
            rd2 = '0;
        end else if (wb_en && (ra2 == wb_addr)) begin
            rd2 = wb_data;
        end
    end

`ifdef WB_TRACE_EN
    logic [31:0]   r_retire_cnt;
    logic [AW-1:0] r_last_wb_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt   <= '0;
            r_last_wb_addr <= '0;
        end else begin
            if (instr_in != 32'h0) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
            if (wb_en) begin
                r_last_wb_addr <= wb_addr;
            end
        end
    end

    assign retire_cnt   = r_retire_cnt;
    assign last_wb_addr = r_last_wb_addr;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (wb_en) begin
            $display("WB r%0d <= %h", wb_addr, wb_data);
        end
    end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile: directed vector table,
//            reset sweep, and randomized traffic against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RegWrite_in = 1'b0;
    logic [1:0]    MemtoReg_in = 2'b00;
    logic [DW-1:0] rd_in = '0;
    logic [DW-1:0] alu_result_in = '0;
    logic [31:0]   wa_in = '0;
    logic [DW-1:0] pc4_in = '0;
    logic [31:0]   instr_in = '0;
    logic [AW-1:0] ra1 = '0;
    logic [AW-1:0] ra2 = '0;
    logic [DW-1:0] rd1, rd2, wb_data;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
`ifdef WB_TRACE_EN
    logic [31:0]   retire_cnt;
    logic [AW-1:0] last_wb_addr;
`endif

    int total = 0;
    int bad   = 0;

    wb_regfile #(.DW(DW), .NREG(32), .AW(AW)) dut (
        .clk(clk), .rst(rst), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .rd_in(rd_in), .alu_result_in(alu_result_in), .wa_in(wa_in), .pc4_in(pc4_in),
        .instr_in(instr_in), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef WB_TRACE_EN
        , .retire_cnt(retire_cnt), .last_wb_addr(last_wb_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] rdv;
        logic [31:0] alu;
        logic [31:0] wa;
        logic [31:0] pc4;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_en;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[15];

    // Reference state for the randomized phase.
    logic [31:0] model[32];
    int unsigned retired;

    initial begin
        //            rst we sel rd        alu           wa        pc4       a1  a2   e_rd1         e_rd2         en e_data
        vecs[0]  = '{1'b1, 1'b1, 2'b00, 32'h0,    32'hAA,       32'd9,    32'h0,   5'd9, 5'd0, 32'h0,        32'h0,        1'b0, 32'hAA};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,        32'd9,    32'h0,   5'd9, 5'd1, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 32'h0,    32'hDEADBEEF, 32'd5,    32'h0,   5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,        32'd5,    32'h0,   5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 32'h1234, 32'h5555,     32'd7,    32'h0,   5'd7, 5'd5, 32'h1234,     32'hDEADBEEF, 1'b1, 32'h1234};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 32'h1234, 32'h5555,     32'd31,   32'h404, 5'd7, 5'd31, 32'h1234,    32'h404,      1'b1, 32'h404};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 32'h1234, 32'hCAFE0001, 32'd8,    32'h404, 5'd31, 5'd8, 32'h404,     32'hCAFE0001, 1'b1, 32'hCAFE0001};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h0,    32'hFFFF,     32'd0,    32'h0,   5'd0, 5'd8, 32'h0,        32'hCAFE0001, 1'b0, 32'hFFFF};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,        32'd0,    32'h0,   5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'h0,    32'h77,       32'h23,   32'h0,   5'd3, 5'd3, 32'h77,       32'h77,       1'b1, 32'h77};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,        32'h0,    32'h0,   5'd3, 5'd9, 32'h77,       32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 2'b00, 32'h0,    32'h1,        32'd5,    32'h0,   5'd5, 5'd3, 32'h0,        32'h0,        1'b0, 32'h1};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,        32'd5,    32'h0,   5'd5, 5'd3, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 32'h0,    32'hABC,      32'd12,   32'h0,   5'd12, 5'd7, 32'hABC,     32'h0,        1'b1, 32'hABC};
        vecs[14] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,        32'd12,   32'h0,   5'd12, 5'd0, 32'hABC,     32'h0,        1'b0, 32'h0};

        // Directed vectors: inputs change on the falling edge, checked 1ns later.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; RegWrite_in = vecs[i].we; MemtoReg_in = vecs[i].sel;
            rd_in = vecs[i].rdv; alu_result_in = vecs[i].alu; wa_in = vecs[i].wa;
            pc4_in = vecs[i].pc4; ra1 = vecs[i].a1; ra2 = vecs[i].a2; instr_in = 32'h0;
            #1;
            chk($sformatf("vec%0d rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("vec%0d rd2", i), rd2, vecs[i].e_rd2);
            chk($sformatf("vec%0d wb_en", i), {31'b0, wb_en}, {31'b0, vecs[i].e_en});
            chk($sformatf("vec%0d wb_data", i), wb_data, vecs[i].e_data);
            if (vecs[i].e_en) chk($sformatf("vec%0d wb_addr", i), {27'b0, wb_addr}, {27'b0, vecs[i].wa[4:0]});
        end

        // Reset sweep: one reset cycle, then every index reads zero on both ports.
        @(negedge clk); rst = 1'b1; RegWrite_in = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            chk($sformatf("reset rd1[%0d]", i), rd1, 32'h0);
            chk($sformatf("reset rd2[%0d]", 31 - i), rd2, 32'h0);
        end

        // Randomized traffic; starts with a reset so model and DUT agree.
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        retired = 0;
        @(negedge clk); rst = 1'b1; instr_in = 32'h0;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] exp_d, e1, e2;
            logic        exp_en;
            logic [4:0]  wa5;
            @(negedge clk);
            rst = ($urandom_range(0, 19) == 0);
            RegWrite_in = ($urandom_range(0, 3) != 0);
            MemtoReg_in = 2'($urandom_range(0, 3));
            rd_in = $urandom; alu_result_in = $urandom; pc4_in = $urandom;
            wa_in = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3) * 32) : $urandom;
            instr_in = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom | 32'h1;
            wa5 = wa_in[4:0];
            ra1 = ($urandom_range(0, 2) == 0) ? wa5 : 5'($urandom);
            ra2 = ($urandom_range(0, 2) == 0) ? wa5 : 5'($urandom);
            exp_d  = (MemtoReg_in == 2'b01) ? rd_in : (MemtoReg_in == 2'b10) ? pc4_in : alu_result_in;
            exp_en = RegWrite_in && (wa5 != 0) && !rst;
            e1 = (rst || ra1 == 0) ? 32'h0 : (exp_en && ra1 == wa5) ? exp_d : model[ra1];
            e2 = (rst || ra2 == 0) ? 32'h0 : (exp_en && ra2 == wa5) ? exp_d : model[ra2];
            #1;
            chk("rand rd1", rd1, e1);
            chk("rand rd2", rd2, e2);
            chk("rand wb_en", {31'b0, wb_en}, {31'b0, exp_en});
            chk("rand wb_data", wb_data, exp_d);
            if (exp_en) chk("rand wb_addr", {27'b0, wb_addr}, {27'b0, wa5});
`ifdef WB_TRACE_EN
            chk("rand retire_cnt", retire_cnt, retired);
`endif
            // Model commit for the coming rising edge.
            if (rst) begin
                for (int k = 0; k < 32; k++) model[k] = 32'h0;
                retired = 0;
            end else begin
                if (exp_en) model[wa5] = exp_d;
                if (instr_in != 32'h0) retired++;
            end
        end

        @(negedge clk);
        rst = 1'b0; RegWrite_in = 1'b0; instr_in = 32'h0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
